// File: rtl/abp_receiver_controller.sv
// Alternating-bit-protocol receive controller: checks frame sequence bits, delivers
// in-order payloads over AXI-Stream, requests ACKs and counts duplicate/error frames.
module abp_receiver_controller #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             rx_done,
  input  logic             rx_seq_bit,
  input  logic             rx_len_err,
  input  logic [63:0]      rx_value,
  output logic             expected_bit,
  output logic             rx_release,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [63:0]      m_tdata,
  output logic             ack_req,
  output logic             ack_bit,
  input  logic             ack_done,
  output logic [CNT_W-1:0] dup_count,
  output logic [CNT_W-1:0] err_count,
  output logic             ack_timeout,
  output logic [1:0]       fsm_state
);

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    DELIVER  = 2'd2,
    SEND_ACK = 2'd3
  } state_t;

  state_t            state, state_d;
  logic              seq_q, seq_d;
  logic              len_err_q, len_err_d;
  logic [63:0]       value_q, value_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              exp_d, ack_bit_d, ack_req_d, m_tvalid_d;
  logic              rx_release_d, ack_timeout_d;
  logic [63:0]       m_tdata_d;
  logic [CNT_W-1:0]  dup_d, err_d;

  assign fsm_state = state;

  // Handshake: m_tdata is held while m_tvalid is high and the beat transfers on the
  // first rising edge where m_tvalid && m_tready; ack_req stays high until an ack_done
  // edge or timeout expiry.
  always_comb begin
    state_d       = state;
    seq_d         = seq_q;
    len_err_d     = len_err_q;
    value_d       = value_q;
    tmo_d         = tmo_q;
    exp_d         = expected_bit;
    ack_bit_d     = ack_bit;
    ack_req_d     = ack_req;
    m_tvalid_d    = m_tvalid;
    m_tdata_d     = m_tdata;
    dup_d         = dup_count;
    err_d         = err_count;
    rx_release_d  = 1'b0;
    ack_timeout_d = 1'b0;

    case (state)
      IDLE: begin
        if (rx_done) begin
          seq_d     = rx_seq_bit;
          len_err_d = rx_len_err;
          value_d   = rx_value;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (len_err_q) begin
          if (err_count != CNT_MAX) err_d = err_count + 1'b1;
          rx_release_d = 1'b1;
          state_d      = IDLE;
        end else if (seq_q == expected_bit) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = value_q;
          state_d    = DELIVER;
        end else begin
          if (dup_count != CNT_MAX) dup_d = dup_count + 1'b1;
          ack_bit_d = seq_q;
          ack_req_d = 1'b1;
          tmo_d     = '0;
          state_d   = SEND_ACK;
        end
      end
      DELIVER: begin
        if (m_tready) begin
          m_tvalid_d = 1'b0;
          exp_d      = ~expected_bit;
          ack_bit_d  = seq_q;
          ack_req_d  = 1'b1;
          tmo_d      = '0;
          state_d    = SEND_ACK;
        end
      end
      SEND_ACK: begin
        // ack_done wins over a coincident expiry.
        if (ack_done) begin
          ack_req_d    = 1'b0;
          rx_release_d = 1'b1;
          state_d      = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          ack_req_d     = 1'b0;
          ack_timeout_d = 1'b1;
          rx_release_d  = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      seq_q        <= 1'b0;
      len_err_q    <= 1'b0;
      value_q      <= '0;
      tmo_q        <= '0;
      expected_bit <= 1'b0;
      ack_bit      <= 1'b0;
      ack_req      <= 1'b0;
      m_tvalid     <= 1'b0;
      m_tdata      <= '0;
      dup_count    <= '0;
      err_count    <= '0;
      rx_release   <= 1'b0;
      ack_timeout  <= 1'b0;
    end else begin
      state        <= state_d;
      seq_q        <= seq_d;
      len_err_q    <= len_err_d;
      value_q      <= value_d;
      tmo_q        <= tmo_d;
      expected_bit <= exp_d;
      ack_bit      <= ack_bit_d;
      ack_req      <= ack_req_d;
      m_tvalid     <= m_tvalid_d;
      m_tdata      <= m_tdata_d;
      dup_count    <= dup_d;
      err_count    <= err_d;
      rx_release   <= rx_release_d;
      ack_timeout  <= ack_timeout_d;
    end
  end

endmodule
